// File: rtl/alu_pkg.sv
// Shared definitions for the ALU host sequencer: op-codes, FSM state encoding
// and a small helper that says which operations return a high result byte.
package alu_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RST    = 3'd1,
      ST_LOAD_A = 3'd2,
      ST_LOAD_B = 3'd3,
      ST_WAIT   = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   function automatic logic has_hi_byte(input logic [1:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_host_sequencer_counter.sv
// Free-running up-counter with synchronous clear (priority) and count enable.
module counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (clr) begin
         count_reg <= '0;
      end else if (en) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/alu_host_sequencer.sv
// Sequences one host command through a handshake-driven ALU (reset, two operand
// loads, wait for END or timeout) and holds the result until the host takes it.
module alu_host_sequencer
   import alu_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [7:0] cmd_a,
   input  logic [7:0] cmd_b,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [7:0] res_hi,
   output logic [7:0] res_lo,
   output logic       res_err,
   output logic       alu_reset,
   output logic       alu_begin,
   output logic [1:0] alu_op_code,
   output logic [7:0] alu_inbus,
   input  logic [7:0] alu_outbus,
   input  logic       alu_end
);

   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

   state_t     state_reg, state_next;
   logic [1:0] op_reg, op_next;
   logic [7:0] a_reg, a_next;
   logic [7:0] b_reg, b_next;
   logic [7:0] shadow_reg, shadow_next;
   logic [7:0] res_hi_reg, res_hi_next;
   logic [7:0] res_lo_reg, res_lo_next;
   logic       res_err_reg, res_err_next;
   logic [7:0] wait_count;

   // Counter runs only while waiting; any other state (or reset) zeroes it.
   counter #(.W(8)) u_wait_counter (
      .clk   (clk),
      .clr   (reset || (state_reg != ST_WAIT)),
      .en    (state_reg == ST_WAIT),
      .count (wait_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         op_reg      <= '0;
         a_reg       <= '0;
         b_reg       <= '0;
         shadow_reg  <= '0;
         res_hi_reg  <= '0;
         res_lo_reg  <= '0;
         res_err_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         op_reg      <= op_next;
         a_reg       <= a_next;
         b_reg       <= b_next;
         shadow_reg  <= shadow_next;
         res_hi_reg  <= res_hi_next;
         res_lo_reg  <= res_lo_next;
         res_err_reg <= res_err_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      op_next      = op_reg;
      a_next       = a_reg;
      b_next       = b_reg;
      shadow_next  = shadow_reg;
      res_hi_next  = res_hi_reg;
      res_lo_next  = res_lo_reg;
      res_err_next = res_err_reg;
      cmd_ready    = 1'b0;
      res_valid    = 1'b0;
      alu_reset    = 1'b0;
      alu_begin    = 1'b0;
      alu_op_code  = 2'b00;
      alu_inbus    = 8'h00;

      case (state_reg)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               op_next    = cmd_op;
               a_next     = cmd_a;
               b_next     = cmd_b;
               state_next = ST_RST;
            end
         end
         ST_RST: begin
            alu_reset  = 1'b1;
            state_next = ST_LOAD_A;
         end
         ST_LOAD_A: begin
            alu_begin   = 1'b1;
            alu_op_code = op_reg;
            alu_inbus   = a_reg;
            state_next  = ST_LOAD_B;
         end
         ST_LOAD_B: begin
            alu_op_code = op_reg;
            alu_inbus   = b_reg;
            state_next  = ST_WAIT;
         end
         ST_WAIT: begin
            alu_op_code = op_reg;
            // The ALU presents the high byte one cycle before END and the low
            // byte with END, so the shadow keeps last cycle's bus value.
            shadow_next = alu_outbus;
            if (alu_end) begin
               res_lo_next  = alu_outbus;
               res_hi_next  = has_hi_byte(op_reg) ? shadow_reg : 8'h00;
               res_err_next = 1'b0;
               state_next   = ST_DONE;
            end else if (wait_count == LAST_WAIT) begin
               res_lo_next  = 8'h00;
               res_hi_next  = 8'h00;
               res_err_next = 1'b1;
               state_next   = ST_DONE;
            end
         end
         ST_DONE: begin
            res_valid   = 1'b1;
            alu_op_code = op_reg;
            if (res_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign res_hi  = res_hi_reg;
   assign res_lo  = res_lo_reg;
   assign res_err = res_err_reg;

endmodule

// File: tb/tb_alu_host_sequencer.sv
// Randomized bench for alu_host_sequencer with a cycle-stepped ALU stand-in and
// an arithmetic reference for the expected results and latency.
module tb_alu_host_sequencer;

   localparam int TIMEOUT = 64;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [7:0] cmd_a;
   logic [7:0] cmd_b;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_hi;
   logic [7:0] res_lo;
   logic       res_err;
   logic       alu_reset;
   logic       alu_begin;
   logic [1:0] alu_op_code;
   logic [7:0] alu_inbus;
   logic [7:0] alu_outbus;
   logic       alu_end;

   int n_vec = 0;
   int n_mis = 0;

   alu_host_sequencer #(.TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_a       (cmd_a),
      .cmd_b       (cmd_b),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_hi      (res_hi),
      .res_lo      (res_lo),
      .res_err     (res_err),
      .alu_reset   (alu_reset),
      .alu_begin   (alu_begin),
      .alu_op_code (alu_op_code),
      .alu_inbus   (alu_inbus),
      .alu_outbus  (alu_outbus),
      .alu_end     (alu_end)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmd_ready"}, int'(cmd_ready), 1);
      check({tag, "_res_valid"}, int'(res_valid), 0);
      check({tag, "_res_hi"}, int'(res_hi), 0);
      check({tag, "_res_lo"}, int'(res_lo), 0);
      check({tag, "_res_err"}, int'(res_err), 0);
      check({tag, "_alu_reset"}, int'(alu_reset), 0);
      check({tag, "_alu_begin"}, int'(alu_begin), 0);
      check({tag, "_alu_op_code"}, int'(alu_op_code), 0);
      check({tag, "_alu_inbus"}, int'(alu_inbus), 0);
   endtask

   // lat = WAIT cycle in which the ALU raises END (>=2), 0 = never.
   // abort_k > 0 pulses reset during that WAIT cycle instead of finishing.
   task automatic run_op(input logic [1:0] op, input int a, input int b,
                         input int lat, input int hold, input int abort_k);
      int  exp_hi, exp_lo, exp_err, alu_hi, alu_lo, n_wait, cyc;
      logic done;
      case (op)
         2'd0: begin alu_lo = (a + b) % 256;       alu_hi = $urandom_range(255); exp_hi = 0; end
         2'd1: begin alu_lo = (a - b + 256) % 256; alu_hi = $urandom_range(255); exp_hi = 0; end
         2'd2: begin alu_lo = (a * b) % 256; alu_hi = (a * b) / 256; exp_hi = alu_hi; end
         default: begin alu_lo = a / b; alu_hi = a % b; exp_hi = alu_hi; end
      endcase
      exp_lo  = alu_lo;
      exp_err = 0;
      n_wait  = lat;
      if (lat == 0) begin
         exp_hi  = 0;
         exp_lo  = 0;
         exp_err = 1;
         n_wait  = TIMEOUT;
      end

      @(negedge clk);
      check("cmd_ready_idle", int'(cmd_ready), 1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = 8'(a);
      cmd_b     = 8'(b);
      res_ready = 1'b0;
      @(posedge clk);
      cyc = 1;
      #1;
      cmd_valid = 1'b0;
      cmd_a     = 8'($urandom);
      cmd_b     = 8'($urandom);

      @(negedge clk);
      check("rst_alu_reset", int'(alu_reset), 1);
      check("rst_alu_begin", int'(alu_begin), 0);
      check("rst_cmd_ready", int'(cmd_ready), 0);
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check("load_a_begin", int'(alu_begin), 1);
      check("load_a_inbus", int'(alu_inbus), a);
      check("load_a_op", int'(alu_op_code), int'(op));
      check("load_a_alu_reset", int'(alu_reset), 0);
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check("load_b_begin", int'(alu_begin), 0);
      check("load_b_inbus", int'(alu_inbus), b);
      check("load_b_op", int'(alu_op_code), int'(op));
      alu_end    = 1'b1;
      alu_outbus = 8'($urandom);
      @(posedge clk);
      cyc++;

      done = 1'b0;
      for (int k = 1; k <= TIMEOUT + 8; k++) begin
         @(negedge clk);
         if (res_valid) begin
            done = 1'b1;
            break;
         end
         check("wait_inbus", int'(alu_inbus), 0);
         if (k == abort_k) begin
            reset   = 1'b1;
            alu_end = 1'b0;
            @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            check_reset_outputs("abort");
            return;
         end
         if (lat > 0 && k == lat) begin
            alu_outbus = 8'(alu_lo);
            alu_end    = 1'b1;
         end else if (lat > 0 && k == lat - 1) begin
            alu_outbus = 8'(alu_hi);
            alu_end    = 1'b0;
         end else begin
            alu_outbus = 8'($urandom);
            alu_end    = 1'b0;
         end
         @(posedge clk);
         cyc++;
      end
      alu_end = 1'b0;
      check("res_valid_seen", int'(done), 1);
      check("latency", cyc, 4 + n_wait);
      check("res_lo", int'(res_lo), exp_lo);
      check("res_hi", int'(res_hi), exp_hi);
      check("res_err", int'(res_err), exp_err);
      check("done_op", int'(alu_op_code), int'(op));
      check("done_cmd_ready", int'(cmd_ready), 0);

      cmd_valid = 1'b1;
      cmd_op    = 2'($urandom);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         @(negedge clk);
         check("hold_res_valid", int'(res_valid), 1);
         check("hold_res_lo", int'(res_lo), exp_lo);
         check("hold_res_hi", int'(res_hi), exp_hi);
         check("hold_res_err", int'(res_err), exp_err);
         check("hold_cmd_ready", int'(cmd_ready), 0);
      end
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;
      cmd_valid = 1'b0;
      check("release_res_valid", int'(res_valid), 0);
      check("release_cmd_ready", int'(cmd_ready), 1);
      check("release_alu_reset", int'(alu_reset), 0);
      $display("op=%0d a=%0d b=%0d lat=%0d hold=%0d -> hi=%0d lo=%0d err=%0d",
               op, a, b, lat, hold, exp_hi, exp_lo, exp_err);
   endtask

   initial begin
      logic [1:0] rop;
      int         ra, rb;
      reset      = 1'b1;
      cmd_valid  = 1'b0;
      cmd_op     = 2'b00;
      cmd_a      = 8'h00;
      cmd_b      = 8'h00;
      res_ready  = 1'b0;
      alu_outbus = 8'h00;
      alu_end    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b0;

      run_op(2'd0, 56, 89, 3, 1, 0);
      run_op(2'd1, 56, 89, 4, 0, 0);
      run_op(2'd2, 56, 89, 2, 2, 0);
      run_op(2'd3, 200, 89, 5, 0, 0);
      run_op(2'd2, 56, 89, 0, 5, 0);

      run_op(2'd2, 56, 89, 6, 0, 3);
      @(posedge clk);
      @(negedge clk);
      check("post_abort_idle", int'(cmd_ready), 1);
      run_op(2'd0, 1, 2, 2, 0, 0);

      for (int i = 0; i < 40; i++) begin
         rop = 2'($urandom);
         ra  = $urandom_range(255);
         rb  = (rop == 2'd3) ? $urandom_range(255, 1) : $urandom_range(255);
         run_op(rop, ra, rb, $urandom_range(8, 2), $urandom_range(3), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
